// File: rtl/conv_encoder_param.sv
// conv_encoder_param
// Parametrised rate-1/2 convolutional encoder with valid/ready handshaking on
// both sides. The generators G0/G1 are K bits wide, and bit K-1 taps the
// current input bit. The legal constraint lengths are 3..9.
//
// Build option CONV_TAIL_EN:
//   defined   - K-1 zero bits are encoded after every FRAME_LEN data bits,
//               which leaves each frame in state 0. out_last marks the final
//               tail symbol, and out_tail marks the tail symbols.
//   undefined - encoding is continuous. out_last marks every FRAME_LEN-th
//               symbol, and out_tail stays 0.
module conv_encoder_param #(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       res,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ip,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] op,
    output logic       out_last,
    output logic       out_tail
);
    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Shift register: sr_reg[K-2] holds the newest prior bit, sr_reg[0] the oldest.
    logic [K-2:0]     sr_reg, sr_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;

    // Output symbol register
    logic       out_valid_reg, out_valid_next;
    logic [1:0] op_reg, op_next;
    logic       out_last_reg, out_last_next;
    logic       out_tail_reg, out_tail_next;

    logic         slot_free;
    logic         enc_d;
    logic         load;
    logic         load_last;
    logic         load_tail;
    logic [K-1:0] win;
    logic [K-1:0] tap_g0;
    logic [K-1:0] tap_g1;
    logic         par_g0;
    logic         par_g1;

`ifdef CONV_TAIL_EN
    localparam int                TAIL_W    = $clog2(K);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(K - 2);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [TAIL_W-1:0] tail_cnt_reg, tail_cnt_next;
`endif

    // The output slot can take a new symbol when it is empty or drains this cycle.
    assign slot_free = !out_valid_reg || out_ready;

`ifdef CONV_TAIL_EN
    // Tail steps push zeros through the shift register.
    assign enc_d = (state_reg == ST_TAIL) ? 1'b0 : ip;
`else
    assign enc_d = ip;
`endif

    // Encoder window {d, sr}, masked per generator and then reduced to parity.
    assign win = {enc_d, sr_reg};

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_tap
            assign tap_g0[gi] = win[gi] & G0[gi];
            assign tap_g1[gi] = win[gi] & G1[gi];
        end
    endgenerate

    assign par_g0 = ^tap_g0;
    assign par_g1 = ^tap_g1;

`ifdef CONV_TAIL_EN
    // Next-state logic. DATA accepts data bits, and TAIL inserts K-1 zero symbols.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tail_cnt_next = tail_cnt_reg;
        in_ready      = 1'b0;
        load          = 1'b0;
        load_last     = 1'b0;
        load_tail     = 1'b0;
        case (state_reg)
            ST_DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load = 1'b1;
                    if (bit_cnt_reg == LAST_CNT) begin
                        bit_cnt_next = '0;
                        state_next   = ST_TAIL;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_tail = 1'b1;
                    if (tail_cnt_reg == TAIL_LAST) begin
                        load_last     = 1'b1;
                        tail_cnt_next = '0;
                        state_next    = ST_DATA;
                    end else begin
                        tail_cnt_next = tail_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_DATA;
            end
        endcase
    end

    // FSM state and tail counter registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg    <= ST_DATA;
            tail_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tail_cnt_reg <= tail_cnt_next;
        end
    end
`else
    // Continuous encoding. The bit counter only marks frame boundaries on out_last.
    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        in_ready     = slot_free;
        load         = 1'b0;
        load_last    = 1'b0;
        load_tail    = 1'b0;
        if (in_valid && slot_free) begin
            load = 1'b1;
            if (bit_cnt_reg == LAST_CNT) begin
                bit_cnt_next = '0;
                load_last    = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
    end
`endif

    // Output register: on a load, overwrite it even if the slot drains in the
    // same cycle. Otherwise, drain it when it is consumed.
    always_comb begin
        sr_next        = sr_reg;
        op_next        = op_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_tail_next  = out_tail_reg;
        if (load) begin
            sr_next        = {enc_d, sr_reg[K-2:1]};
            op_next        = {par_g0, par_g1};
            out_valid_next = 1'b1;
            out_last_next  = load_last;
            out_tail_next  = load_tail;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // Datapath registers: shift register, bit counter and output symbol
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            op_reg        <= 2'b00;
            out_last_reg  <= 1'b0;
            out_tail_reg  <= 1'b0;
        end else begin
            sr_reg        <= sr_next;
            bit_cnt_reg   <= bit_cnt_next;
            out_valid_reg <= out_valid_next;
            op_reg        <= op_next;
            out_last_reg  <= out_last_next;
            out_tail_reg  <= out_tail_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign op        = op_reg;
    assign out_last  = out_last_reg;
    assign out_tail  = out_tail_reg;

endmodule

// File: tb/tb_conv_encoder_param.sv
// tb_conv_encoder_param
// Self-checking bench for conv_encoder_param with K=3, G0=111, G1=101 and
// FRAME_LEN=4. Expected symbols {op, out_last, out_tail} are pushed to a queue
// when an input is accepted, and they are popped when the DUT hands a symbol
// over. Table checks use hand-derived vectors for the build selected by CONV_TAIL_EN.
module tb_conv_encoder_param;
    localparam int           K         = 3;
    localparam logic [K-1:0] G0        = 3'b111;
    localparam logic [K-1:0] G1        = 3'b101;
    localparam int           FRAME_LEN = 4;

    localparam logic [0:7] BITS1 = 8'b11011101;

`ifdef CONV_TAIL_EN
    localparam int N1_BITS     = 4;
    localparam int N1_SYM      = 6;
    localparam int EXP1_LOW    = 2;
    localparam int N_FRAME_SYM = 6;
    localparam int RST_AT      = 5;
    localparam int ONES_IDX    = 6;
    localparam logic [3:0] ONES_EXP = 4'b1100;
    localparam logic [3:0] EXP1 [0:7] = '{4'b1100, 4'b0100, 4'b0100, 4'b0000,
                                          4'b1001, 4'b1111, 4'b0000, 4'b0000};
`else
    localparam int N1_BITS     = 8;
    localparam int N1_SYM      = 8;
    localparam int EXP1_LOW    = 0;
    localparam int N_FRAME_SYM = 4;
    localparam int RST_AT      = 2;
    localparam int ONES_IDX    = 4;
    localparam logic [3:0] ONES_EXP = 4'b1000;
    localparam logic [3:0] EXP1 [0:7] = '{4'b1100, 4'b0100, 4'b0100, 4'b0010,
                                          4'b0100, 4'b1000, 4'b0100, 4'b0010};
`endif

    logic       clk = 1'b0;
    logic       res;
    logic       in_valid;
    logic       in_ready;
    logic       ip;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] op;
    logic       out_last;
    logic       out_tail;

    int checks = 0;
    int errors = 0;

    // Per-cycle observation filled in by tick()
    logic       t_acc, t_con, t_ir, t_ov;
    logic [3:0] t_sym;

    // Reference model state and scoreboard
    logic [K-2:0] m_sr;
    int           m_cnt;
    int           m_tails;
    logic [3:0]   sb_q[$];

    conv_encoder_param #(
        .K(K), .G0(G0), .G1(G1), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .ip(ip),
        .out_valid(out_valid), .out_ready(out_ready), .op(op),
        .out_last(out_last), .out_tail(out_tail)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_sr    = '0;
        m_cnt   = 0;
        m_tails = 0;
        sb_q.delete();
    endtask

    task automatic model_encode(input logic d, input logic last, input logic tail);
        logic [K-1:0] w;
        w    = {d, m_sr};
        m_sr = {d, m_sr[K-2:1]};
        sb_q.push_back({^(w & G0), ^(w & G1), last, tail});
        if (tail) m_tails++;
    endtask

    task automatic model_accept(input logic d);
        m_cnt++;
`ifdef CONV_TAIL_EN
        model_encode(d, 1'b0, 1'b0);
        if (m_cnt == FRAME_LEN) begin
            m_cnt = 0;
            for (int i = 0; i < K - 1; i++) model_encode(1'b0, (i == K - 2), 1'b1);
        end
`else
        model_encode(d, (m_cnt == FRAME_LEN), 1'b0);
        if (m_cnt == FRAME_LEN) m_cnt = 0;
`endif
    endtask

    // Called at a falling edge with inputs already driven. Samples the
    // handshake 1 ns later, then advances to the next falling edge.
    task automatic tick();
        #1;
        t_acc = in_valid && in_ready;
        t_con = out_valid && out_ready;
        t_ir  = in_ready;
        t_ov  = out_valid;
        t_sym = {op, out_last, out_tail};
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 res = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (op !== 2'b00)       begin errors++; $display("FAIL rst_op: got %b required 00", op); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        checks++; if (out_tail !== 1'b0)  begin errors++; $display("FAIL rst_out_tail: got %b required 0", out_tail); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        tick();
        checks++; if (t_ov !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b required 0", t_ov); end
        $display("test_reset done");
    endtask

    task automatic test_frame_1101();
        int idx = 0, k = 0, low = 0, cyc = 0;
        logic [3:0] exp;
        out_ready = 1'b1;
        while (k < N1_SYM && cyc < 60) begin
            in_valid = (idx < N1_BITS);
            ip       = (idx < N1_BITS) ? BITS1[idx] : 1'b0;
            tick();
            cyc++;
            if (!t_ir) low++;
            if (t_acc) begin
                checks++;
                if (m_tails > 1) begin errors++; $display("FAIL f1101_accept_in_tail: got in_ready 1 required 0"); end
                model_accept(ip);
                idx++;
            end
            if (t_con) begin
                checks++;
                if (t_sym !== EXP1[k]) begin errors++; $display("FAIL f1101_sym%0d: got %b required %b", k, t_sym, EXP1[k]); end
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    if (exp[0]) m_tails--;
                end
                $display("f1101 sym %0d op=%b last=%b tail=%b", k, t_sym[3:2], t_sym[1], t_sym[0]);
                k++;
            end
        end
        in_valid = 1'b0;
        checks++; if (k != N1_SYM)       begin errors++; $display("FAIL f1101_count: got %0d required %0d", k, N1_SYM); end
        checks++; if (low != EXP1_LOW)   begin errors++; $display("FAIL f1101_inready_low: got %0d required %0d", low, EXP1_LOW); end
        checks++; if (cyc != N1_SYM + 1) begin errors++; $display("FAIL f1101_throughput: got %0d cycles required %0d", cyc, N1_SYM + 1); end
        tick();
        tick();
        checks++; if (t_ov !== 1'b0) begin errors++; $display("FAIL f1101_extra_out: got %b required 0", t_ov); end
    endtask

    task automatic test_all_ones();
        int idx = 0, k = 0, cyc = 0;
        logic [3:0] exp;
        out_ready = 1'b1;
        while ((idx < 2 * FRAME_LEN || sb_q.size() != 0) && cyc < 100) begin
            in_valid = (idx < 2 * FRAME_LEN);
            ip       = 1'b1;
            tick();
            cyc++;
            if (t_acc) begin
                checks++;
                if (m_tails > 1) begin errors++; $display("FAIL ones_accept_in_tail: got in_ready 1 required 0"); end
                model_accept(ip);
                idx++;
            end
            if (t_con) begin
                checks++;
                if (sb_q.size() == 0) begin errors++; $display("FAIL ones_sb: got %b required none", t_sym); end
                else begin
                    exp = sb_q.pop_front();
                    if (exp[0]) m_tails--;
                    if (t_sym !== exp) begin errors++; $display("FAIL ones_sb%0d: got %b required %b", k, t_sym, exp); end
                end
                if (k == ONES_IDX) begin
                    checks++;
                    if (t_sym !== ONES_EXP) begin errors++; $display("FAIL ones_frame2_first: got %b required %b", t_sym, ONES_EXP); end
                end
                $display("ones sym %0d op=%b last=%b tail=%b", k, t_sym[3:2], t_sym[1], t_sym[0]);
                k++;
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (t_ov !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL ones_drain: got valid %b pending %0d required 0 0", t_ov, sb_q.size()); end
    endtask

    task automatic test_backpressure();
        int idx = 0, k = 0, cyc = 0;
        logic [3:0] exp, prev_sym = 4'b0;
        logic prev_stall = 1'b0;
        while ((idx < 8 || sb_q.size() != 0) && cyc < 400) begin
            in_valid  = (idx < 8) && ($urandom_range(0, 9) < 7);
            ip        = in_valid ? BITS1[idx % 8] : 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (prev_stall) begin
                checks++;
                if (t_ov !== 1'b1 || t_sym !== prev_sym) begin
                    errors++; $display("FAIL bp_hold: got valid %b sym %b required 1 %b", t_ov, t_sym, prev_sym);
                end
            end
            prev_stall = t_ov && !out_ready;
            prev_sym   = t_sym;
            if (t_acc) begin
                checks++;
                if (m_tails > 1) begin errors++; $display("FAIL bp_accept_in_tail: got in_ready 1 required 0"); end
                model_accept(ip);
                idx++;
            end
            if (t_con) begin
                checks++;
                if (sb_q.size() == 0) begin errors++; $display("FAIL bp_sb: got %b required none", t_sym); end
                else begin
                    exp = sb_q.pop_front();
                    if (exp[0]) m_tails--;
                    if (t_sym !== exp) begin errors++; $display("FAIL bp_sb%0d: got %b required %b", k, t_sym, exp); end
                end
                $display("bp sym %0d op=%b last=%b tail=%b", k, t_sym[3:2], t_sym[1], t_sym[0]);
                k++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (t_ov !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL bp_drain: got valid %b pending %0d required 0 0", t_ov, sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        int idx = 0, k = 0, n_con = 0, cyc = 0;
        logic [3:0] exp;
        out_ready = 1'b1;
        while (n_con < RST_AT && cyc < 60) begin
            in_valid = (idx < 8);
            ip       = BITS1[idx % 8];
            tick();
            cyc++;
            if (t_acc) begin model_accept(ip); idx++; end
            if (t_con) begin
                checks++;
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : 4'bxxxx;
                if (exp[0] === 1'b1) m_tails--;
                if (t_sym !== exp) begin errors++; $display("FAIL rm_pre%0d: got %b required %b", n_con, t_sym, exp); end
                n_con++;
            end
        end
        in_valid = 1'b0;
        res      = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b required 0", out_valid); end
        checks++; if (op !== 2'b00)       begin errors++; $display("FAIL rm_op: got %b required 00", op); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rm_out_last: got %b required 0", out_last); end
        checks++; if (out_tail !== 1'b0)  begin errors++; $display("FAIL rm_out_tail: got %b required 0", out_tail); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rm_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
        res = 1'b1;
        model_reset();
        idx = 0;
        cyc = 0;
        while ((idx < FRAME_LEN || sb_q.size() != 0) && cyc < 60) begin
            in_valid = (idx < FRAME_LEN);
            ip       = BITS1[idx % 8];
            tick();
            cyc++;
            if (t_acc) begin model_accept(ip); idx++; end
            if (t_con) begin
                checks++;
                if (k < N_FRAME_SYM && t_sym !== EXP1[k]) begin errors++; $display("FAIL rm_post_tbl%0d: got %b required %b", k, t_sym, EXP1[k]); end
                if (sb_q.size() == 0) begin errors++; $display("FAIL rm_post_sb: got %b required none", t_sym); end
                else begin
                    exp = sb_q.pop_front();
                    if (exp[0]) m_tails--;
                    if (t_sym !== exp) begin errors++; $display("FAIL rm_post_sb%0d: got %b required %b", k, t_sym, exp); end
                end
                $display("rm sym %0d op=%b last=%b tail=%b", k, t_sym[3:2], t_sym[1], t_sym[0]);
                k++;
            end
        end
        in_valid = 1'b0;
        checks++; if (k != N_FRAME_SYM) begin errors++; $display("FAIL rm_post_count: got %0d required %0d", k, N_FRAME_SYM); end
        tick();
        tick();
        checks++; if (t_ov !== 1'b0) begin errors++; $display("FAIL rm_drain: got %b required 0", t_ov); end
    endtask

    task automatic test_zeros();
        int idx = 0, k = 0, cyc = 0;
        logic [3:0] exp;
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        model_reset();
        while ((idx < 2 * FRAME_LEN || sb_q.size() != 0) && cyc < 300) begin
            in_valid  = (idx < 2 * FRAME_LEN);
            ip        = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (t_acc) begin model_accept(ip); idx++; end
            if (t_con) begin
                checks++;
                if (t_sym[3:2] !== 2'b00) begin errors++; $display("FAIL zero_op%0d: got %b required 00", k, t_sym[3:2]); end
                checks++;
                if (sb_q.size() == 0) begin errors++; $display("FAIL zero_sb: got %b required none", t_sym); end
                else begin
                    exp = sb_q.pop_front();
                    if (exp[0]) m_tails--;
                    if (t_sym !== exp) begin errors++; $display("FAIL zero_sb%0d: got %b required %b", k, t_sym, exp); end
                end
                $display("zero sym %0d op=%b last=%b tail=%b", k, t_sym[3:2], t_sym[1], t_sym[0]);
                k++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (t_ov !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL zero_drain: got valid %b pending %0d required 0 0", t_ov, sb_q.size()); end
    endtask

    initial begin
        res       = 1'b1;
        in_valid  = 1'b0;
        ip        = 1'b0;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_frame_1101();
        test_all_ones();
        test_backpressure();
        test_reset_mid();
        test_zeros();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
